// File: rtl/systolic_array_wrapper_core.sv
// rtl/systolic_array_wrapper_core.sv - AXI4-Lite 3x3 conv tile: 6x6x8 activations, 8 output channels, sequential MAC
//
// Purpose: holds the activation, weight and output register files plus a
// 64-MAC engine that processes one kernel position (kij) per cycle. Each
// output pixel takes 9 COMPUTE cycles and 1 STORE cycle. A full pass is 16 pixels.
//
// Ports:
//   s_axi_aclk / s_axi_aresetn  clock, synchronous active-low reset
//   s_axi_aw* / s_axi_w* / s_axi_b*  AXI4-Lite write channel (prot, strb ignored)
//   s_axi_ar* / s_axi_r*             AXI4-Lite read channel
//
// Parameters:
//   C_S_AXI_DATA_WIDTH  must be 32
//   C_S_AXI_ADDR_WIDTH  byte address width (12)
//   WEIGHT_FILE         name of the weight image. Weights have no reset, and
//                       software programs them through the WGT window.
//
// Build option: define RELU_EN to clamp negative 16-bit columns to 0 on STORE.
module systolic_array_wrapper_core #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter     WEIGHT_FILE        = "weight.txt"
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_STORE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam bit HAS_WEIGHT_FILE = (WEIGHT_FILE != "");

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb,
                         s_axi_awaddr[1:0], s_axi_araddr[1:0], HAS_WEIGHT_FILE};

    // Register files
    logic [31:0]  act_q [36];
    logic [31:0]  wgt_q [72];
    logic [127:0] out_q [16];
    logic [15:0]  acc_q [8];

    // FSM state
    state_t       state_q;
    logic [3:0]   kij_q;
    logic [3:0]   onij_q;
    logic         done_q;
    logic         start_q;

    // AXI channel state
    logic         awready_q, bvalid_q;
    logic         arready_q, rvalid_q;
    logic [31:0]  rdata_q;

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;

    // ---------------- write channel ----------------
    logic [9:0] wa;
    logic       wr_hs;
    logic       wr_act, wr_wgt, wr_start;
    logic [5:0] wr_act_idx;
    logic [6:0] wr_wgt_idx;

    assign wa         = s_axi_awaddr[11:2];
    assign wr_hs      = awready_q && s_axi_awvalid && s_axi_wvalid;
    assign wr_act     = wr_hs && (wa >= 10'd2) && (wa <= 10'd37);
    assign wr_wgt     = wr_hs && (wa >= 10'd256) && (wa <= 10'd327);
    assign wr_act_idx = 6'(wa - 10'd2);
    assign wr_wgt_idx = 7'(wa - 10'd256);
    // A start is only latched from IDLE, so writes during a run are dropped.
    assign wr_start   = wr_hs && (wa == 10'd0) && s_axi_wdata[0] && (state_q == S_IDLE);

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            // The !awready_q term makes the ready a single-cycle pulse.
            awready_q <= s_axi_awvalid && s_axi_wvalid && !bvalid_q && !awready_q;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
            end else if (s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < 36; i++) begin
                act_q[i] <= 32'd0;
            end
        end else if (wr_act) begin
            act_q[wr_act_idx] <= s_axi_wdata[31:0];
        end
    end

    // Weights deliberately survive reset.
    always_ff @(posedge s_axi_aclk) begin
        if (wr_wgt) begin
            wgt_q[wr_wgt_idx] <= s_axi_wdata[31:0];
        end
    end

    // ---------------- MAC datapath ----------------
    logic [5:0]   ki6, kj6, act_idx;
    logic [31:0]  act_word;
    logic [31:0]  wgt_sel [8];
    logic [15:0]  mac_d [8];
    logic [127:0] store_word;

    assign ki6     = {2'b00, kij_q / 4'd3};
    assign kj6     = {2'b00, kij_q % 4'd3};
    // Window origin is (oy, ox) = (onij[3:2], onij[1:0]) inside the 6x6 tile.
    assign act_idx = ({4'b0, onij_q[3:2]} + ki6) * 6'd6 + {4'b0, onij_q[1:0]} + kj6;

    always_comb begin
        act_word = act_q[act_idx];
        for (int c = 0; c < 8; c++) begin
            wgt_sel[c] = wgt_q[{kij_q, 3'(c)}];
            mac_d[c]   = acc_q[c];
            for (int r = 0; r < 8; r++) begin
                // Unsigned activation times sign-extended weight, both widened to
                // 16 bits. The truncated product equals the signed product mod 2^16.
                mac_d[c] = mac_d[c] + ({12'b0, act_word[4*r +: 4]} *
                           {{12{wgt_sel[c][4*r+3]}}, wgt_sel[c][4*r +: 4]});
            end
        end
    end

    always_comb begin
        store_word = '0;
        for (int c = 0; c < 8; c++) begin
`ifdef RELU_EN
            store_word[16*c +: 16] = acc_q[c][15] ? 16'd0 : acc_q[c];
`else
            store_word[16*c +: 16] = acc_q[c];
`endif
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_q <= S_IDLE;
            kij_q   <= 4'd0;
            onij_q  <= 4'd0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            for (int c = 0; c < 8; c++) begin
                acc_q[c] <= 16'd0;
            end
            for (int o = 0; o < 16; o++) begin
                out_q[o] <= 128'd0;
            end
        end else begin
            start_q <= wr_start;
            case (state_q)
                S_IDLE: begin
                    if (start_q) begin
                        state_q <= S_COMPUTE;
                        done_q  <= 1'b0;
                        kij_q   <= 4'd0;
                        onij_q  <= 4'd0;
                        for (int c = 0; c < 8; c++) begin
                            acc_q[c] <= 16'd0;
                        end
                    end
                end
                S_COMPUTE: begin
                    for (int c = 0; c < 8; c++) begin
                        acc_q[c] <= mac_d[c];
                    end
                    if (kij_q == 4'd8) begin
                        state_q <= S_STORE;
                    end else begin
                        kij_q <= kij_q + 4'd1;
                    end
                end
                S_STORE: begin
                    out_q[onij_q] <= store_word;
                    for (int c = 0; c < 8; c++) begin
                        acc_q[c] <= 16'd0;
                    end
                    if (onij_q == 4'd15) begin
                        state_q <= S_DONE;
                    end else begin
                        onij_q  <= onij_q + 4'd1;
                        kij_q   <= 4'd0;
                        state_q <= S_COMPUTE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    logic [9:0]  ra;
    logic        rd_hs;
    logic [31:0] rd_mux;

    assign ra    = s_axi_araddr[11:2];
    assign rd_hs = arready_q && s_axi_arvalid;

    always_comb begin
        rd_mux = 32'd0;
        if (ra == 10'd0) begin
            rd_mux = {29'd0, (state_q == S_IDLE), done_q, 1'b0};
        end else if (ra == 10'd1) begin
            rd_mux = {16'd0, onij_q, kij_q, 6'd0, state_q};
        end else if ((ra >= 10'd2) && (ra <= 10'd37)) begin
            rd_mux = act_q[6'(ra - 10'd2)];
        end else if ((ra >= 10'd64) && (ra <= 10'd127)) begin
            rd_mux = out_q[ra[5:2]][{ra[1:0], 5'd0} +: 32];
        end else if ((ra >= 10'd256) && (ra <= 10'd327)) begin
            rd_mux = wgt_q[7'(ra - 10'd256)];
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            arready_q <= s_axi_arvalid && !rvalid_q && !arready_q;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_wrapper_core.sv
// tb/tb_systolic_array_wrapper_core.sv - directed and random AXI-Lite bench for the conv tile
module tb_systolic_array_wrapper_core;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [11:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = 4'hF;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [11:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr = 0;

    logic [31:0] m_act [36];
    logic [31:0] m_wgt [72];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_array_wrapper_core dut (
        .s_axi_aclk(clk), .s_axi_aresetn(resetn),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Drive after an edge; the handshake edge is recorded in last_wr.
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
        int n;
        n = 0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        while (awready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        chk("aw_accept", {31'd0, awready & wready}, 32'd1);
        @(posedge clk); #1;
        last_wr = cyc;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid_next", {29'd0, bresp, bvalid}, 32'd1);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
        int n;
        n = 0;
        araddr = a; arvalid = 1'b1;
        while (arready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        chk("ar_accept", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("rvalid_next", {29'd0, rresp, rvalid}, 32'd1);
        d = rdata;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin @(posedge clk); #1; end
    endtask

    task automatic load_all();
        for (int n = 0; n < 36; n++) axi_write(12'(8 + 4 * n), m_act[n]);
        for (int i = 0; i < 72; i++) axi_write(12'(1024 + 4 * i), m_wgt[i]);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] v;
        int n;
        n = 0;
        v = 0;
        while (v[1] !== 1'b1 && n < 100) begin axi_read(12'h000, v); n++; end
        chk($sformatf("%s_done", tag), v, 32'h6);
    endtask

    // Reference: the convolution sum in plain integer arithmetic.
    function automatic logic [15:0] ref_col(int o, int c);
        int s, ox, oy, n, a, wv;
        logic [31:0] sv;
        s = 0; ox = o % 4; oy = o / 4;
        for (int k = 0; k < 9; k++) begin
            for (int r = 0; r < 8; r++) begin
                n  = (oy + k / 3) * 6 + ox + k % 3;
                a  = int'((m_act[n] >> (4 * r)) & 32'hF);
                wv = int'((m_wgt[k * 8 + c] >> (4 * r)) & 32'hF);
                if (wv > 7) wv -= 16;
                s += a * wv;
            end
        end
        sv = s;
`ifdef RELU_EN
        if (sv[15]) sv = 0;
`endif
        return sv[15:0];
    endfunction

    task automatic check_outputs(input string tag);
        logic [31:0] v;
        for (int o = 0; o < 16; o++) begin
            for (int w = 0; w < 4; w++) begin
                axi_read(12'(256 + 16 * o + 4 * w), v);
                chk($sformatf("%s_out%0d_w%0d", tag, o, w), v, {ref_col(o, 2 * w + 1), ref_col(o, 2 * w)});
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        int t0;

        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // Reset state
        axi_read(12'h000, v); chk("rst_ctrl", v, 32'h4);
        axi_read(12'h004, v); chk("rst_status", v, 32'h0);
        axi_read(12'h0FC, v); chk("rst_unmapped", v, 32'h0);
        axi_read(12'h008, v); chk("rst_act0", v, 32'h0);
        axi_read(12'h100, v); chk("rst_out0", v, 32'h0);

        // Writes to read-only and unmapped locations are dropped
        axi_write(12'h0FC, 32'hDEADBEEF);
        axi_write(12'h004, 32'hFFFFFFFF);
        axi_write(12'h100, 32'h12345678);
        axi_read(12'h0FC, v); chk("ro_unmapped", v, 32'h0);
        axi_read(12'h004, v); chk("ro_status", v, 32'h0);
        axi_read(12'h100, v); chk("ro_out", v, 32'h0);

        // All ones: 72 per column; done not yet visible one edge early
        for (int n = 0; n < 36; n++) m_act[n] = 32'h11111111;
        for (int i = 0; i < 72; i++) m_wgt[i] = 32'h11111111;
        load_all();
        axi_read(12'h01C, v); chk("rb_act5", v, 32'h11111111);
        axi_read(12'h4A0, v); chk("rb_wgt40", v, 32'h11111111);
        axi_write(12'h000, 32'h1);
        t0 = last_wr;
        wait_until(t0 + 160);
        axi_read(12'h000, v); chk("ones_not_done_161", v, 32'h0);
        wait_done("ones");
        axi_read(12'h100, v); chk("ones_literal", v, 32'h00480048);
        check_outputs("ones");

        // All -1 weights; second start at cycle 50 must not restart the run
        for (int i = 0; i < 72; i++) m_wgt[i] = 32'hFFFFFFFF;
        for (int i = 0; i < 72; i++) axi_write(12'(1024 + 4 * i), m_wgt[i]);
        axi_write(12'h000, 32'h1);
        t0 = last_wr;
        wait_until(t0 + 48);
        axi_write(12'h000, 32'h1);
        chk("second_start_edge", last_wr - t0, 32'd50);
        wait_until(t0 + 161);
        axi_read(12'h000, v); chk("neg_done_at_162", v, 32'h6);
`ifdef RELU_EN
        axi_read(12'h1F0, v); chk("neg_literal", v, 32'h00000000);
`else
        axi_read(12'h1F0, v); chk("neg_literal", v, 32'hFFB8FFB8);
`endif
        check_outputs("neg");

        // Single tap: kij=4, column 0, channel 0
        for (int n = 0; n < 36; n++) m_act[n] = n;
        for (int i = 0; i < 72; i++) m_wgt[i] = 32'h0;
        m_wgt[32] = 32'h1;
        load_all();
        axi_write(12'h000, 32'h1);
        wait_done("tap");
        axi_read(12'h100, v); chk("tap_o0_literal", v, 32'h7);
        check_outputs("tap");

        // Random datasets
        for (int run = 0; run < 2; run++) begin
            for (int n = 0; n < 36; n++) m_act[n] = $urandom();
            for (int i = 0; i < 72; i++) m_wgt[i] = $urandom();
            load_all();
            axi_write(12'h000, 32'h1);
            wait_done($sformatf("rnd%0d", run));
            check_outputs($sformatf("rnd%0d", run));
        end

        // Reset mid-run aborts cleanly and keeps the weights
        axi_write(12'h000, 32'h1);
        t0 = last_wr;
        wait_until(t0 + 40);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        axi_read(12'h000, v); chk("midrst_ctrl", v, 32'h4);
        axi_read(12'h004, v); chk("midrst_status", v, 32'h0);
        axi_read(12'h100, v); chk("midrst_out0", v, 32'h0);
        axi_read(12'h008, v); chk("midrst_act0", v, 32'h0);
        axi_read(12'h400, v); chk("midrst_wgt0", v, m_wgt[0]);
        axi_read(12'h51C, v); chk("midrst_wgt71", v, m_wgt[71]);
        repeat (20) @(posedge clk);
        #1;
        axi_read(12'h000, v); chk("midrst_stays_idle", v, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
